pool_dp_gen: RTL and testbench

- Parametrised successor to the fixed 2x2 average-pool datapath.
- Accepts a raster-order IFM stream of NUM_CH parallel channel lanes, one pixel per lane per beat, and buffers rows internally.
- Emits max- or average-pooled outputs for any power-of-two kernel and any stride, with valid/ready flow control and a frame FSM.
- Sits between a conv layer's output stream and the next layer's IFM memory writer.

---
 rtl/pool_pkg.sv | 23 ++
 rtl/pool_dp_gen_if.sv | 23 ++
 rtl/pool_window_reduce.sv | 36 +++
 rtl/pool_dp_gen.sv | 179 +++++++++++++++++
 tb/tb_pool_dp_gen.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_pkg.sv
// Shared types and width helpers for the generic pooling datapath.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } pool_state_t;

  localparam logic MODE_AVG = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accumulator width for a K*K sum of data_w-bit samples (K power of two).
  function automatic int acc_w(input int data_w, input int k);
    return data_w + 2 * $clog2(k);
  endfunction

endpackage

// File: rtl/pool_dp_gen_if.sv
// Streaming bus of the pooling datapath: raster pixel input and pooled output,
// both with valid/ready flow control.
interface pool_dp_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2
);
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_WIDTH*NUM_CH-1:0] data_in;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH*NUM_CH-1:0] data_out;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/pool_window_reduce.sv
// Combinational max / floor-average reduction of one lane's K*K window taps.
module pool_window_reduce
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNAL_SIZE = 2
) (
  input  logic                                            mode,
  input  logic [KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH-1:0]   taps,
  output logic signed [DATA_WIDTH-1:0]                    result
);

  localparam int NT    = KERNAL_SIZE * KERNAL_SIZE;
  localparam int SH    = 2 * $clog2(KERNAL_SIZE);
  localparam int ACC_W = acc_w(DATA_WIDTH, KERNAL_SIZE);

  logic signed [DATA_WIDTH-1:0] tap_v;
  logic signed [DATA_WIDTH-1:0] max_v;
  logic signed [DATA_WIDTH-1:0] avg_v;
  logic signed [ACC_W-1:0]      acc;

  always_comb begin
    tap_v = '0;
    max_v = taps[DATA_WIDTH-1:0];
    acc   = '0;
    for (int t = 0; t < NT; t++) begin
      tap_v = taps[t*DATA_WIDTH +: DATA_WIDTH];
      if (tap_v > max_v) max_v = tap_v;
      acc = acc + {{SH{tap_v[DATA_WIDTH-1]}}, tap_v};
    end
    // Arithmetic shift floors toward -inf; the mean of in-range samples always fits.
    avg_v  = DATA_WIDTH'(acc >>> SH);
    result = (mode == MODE_MAX) ? max_v : avg_v;
  end

endmodule

// File: rtl/pool_dp_gen.sv
// Generic KxK / stride-S max/average pooling over a raster multi-lane stream.
// Optional macro POOL_RELU_EN clamps negative pooled results to zero.
module pool_dp_gen
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_CH        = 2,
  parameter int IFM_SIZE      = 14,
  parameter int KERNAL_SIZE   = 2,
  parameter int STRIDE        = 2,
  parameter int IFM_SIZE_NEXT = (IFM_SIZE - KERNAL_SIZE) / STRIDE + 1,
  parameter int FIFO_SIZE     = (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  pool_dp_gen_if.slave  bus,
  output logic          done
);

  localparam int CW   = cnt_w(IFM_SIZE);
  localparam int PH_W = cnt_w(STRIDE);
  localparam int DW   = DATA_WIDTH;
  localparam int NT   = KERNAL_SIZE * KERNAL_SIZE;

  localparam logic [CW-1:0]   FIRST_WIN = CW'(KERNAL_SIZE - 1);
  localparam logic [CW-1:0]   LAST_WIN  = CW'(KERNAL_SIZE - 1 + (IFM_SIZE_NEXT - 1) * STRIDE);
  localparam logic [CW-1:0]   LAST_PX   = CW'(IFM_SIZE - 1);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(STRIDE - 1);

  pool_state_t       state, state_nxt;
  logic [CW-1:0]     row, col;
  logic [PH_W-1:0]   row_ph, col_ph;
  logic              frame_in_done;
  logic              mode_q;
  logic              accept;
  logic              row_ok, col_ok, win_done;
  logic [DW*NUM_CH-1:0] res_all;

  // Stride phase of the next row/column, counted only once the first window edge is reached.
  function automatic logic [PH_W-1:0] ph_step(input logic [PH_W-1:0] ph, input logic past_first);
    if (!past_first || ph == PH_LAST) return '0;
    return ph + 1'b1;
  endfunction

`ifdef POOL_RELU_EN
  function automatic logic signed [DW-1:0] relu_clamp(input logic signed [DW-1:0] v);
    return v[DW-1] ? '0 : v;
  endfunction
`endif

  assign accept   = bus.in_valid && bus.in_ready;
  assign row_ok   = (row >= FIRST_WIN) && (row <= LAST_WIN) && (row_ph == '0);
  assign col_ok   = (col >= FIRST_WIN) && (col <= LAST_WIN) && (col_ph == '0);
  assign win_done = accept && row_ok && col_ok;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        bus.in_ready = !frame_in_done && (!bus.out_valid || bus.out_ready);
        if (frame_in_done && (!bus.out_valid || bus.out_ready)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row           <= '0;
      col           <= '0;
      row_ph        <= '0;
      col_ph        <= '0;
      frame_in_done <= 1'b0;
      mode_q        <= MODE_AVG;
    end else if (state == IDLE && start) begin
      row           <= '0;
      col           <= '0;
      row_ph        <= '0;
      col_ph        <= '0;
      frame_in_done <= 1'b0;
      mode_q        <= mode;
    end else if (state == DONE) begin
      frame_in_done <= 1'b0;
    end else if (accept) begin
      if (col == LAST_PX) begin
        col    <= '0;
        col_ph <= '0;
        if (row == LAST_PX) begin
          row           <= '0;
          row_ph        <= '0;
          frame_in_done <= 1'b1;
        end else begin
          row    <= row + 1'b1;
          row_ph <= ph_step(row_ph, row >= FIRST_WIN);
        end
      end else begin
        col    <= col + 1'b1;
        col_ph <= ph_step(col_ph, col >= FIRST_WIN);
      end
    end
  end

  // Stage p0: per-lane line buffer and window reduction on the accepted beat.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    logic signed [DW-1:0] lane_in;
    logic signed [DW-1:0] sr [FIFO_SIZE-1];
    logic [NT*DW-1:0]     taps;
    logic signed [DW-1:0] pooled;
    logic signed [DW-1:0] lane_res;

    assign lane_in = bus.data_in[ch*DW +: DW];

    always_ff @(posedge clk) begin
      if (accept) begin
        sr[0] <= lane_in;
        for (int n = 1; n < FIFO_SIZE - 1; n++) sr[n] <= sr[n-1];
      end
    end

    // Offset 0 is the beat being accepted, so it taps the input directly.
    for (genvar i = 0; i < KERNAL_SIZE; i++) begin : g_row
      for (genvar j = 0; j < KERNAL_SIZE; j++) begin : g_col
        localparam int OFF = i * IFM_SIZE + j;
        if (OFF == 0) begin : g_live
          assign taps[(i*KERNAL_SIZE+j)*DW +: DW] = lane_in;
        end else begin : g_buf
          assign taps[(i*KERNAL_SIZE+j)*DW +: DW] = sr[OFF-1];
        end
      end
    end

    pool_window_reduce #(
      .DATA_WIDTH  (DW),
      .KERNAL_SIZE (KERNAL_SIZE)
    ) u_reduce (
      .mode   (mode_q),
      .taps   (taps),
      .result (pooled)
    );

`ifdef POOL_RELU_EN
    assign lane_res = relu_clamp(pooled);
`else
    assign lane_res = pooled;
`endif

    assign res_all[ch*DW +: DW] = lane_res;
  end

  // Stage p1: output register; a new window replaces a beat popped in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
    end else if (win_done) begin
      bus.out_valid <= 1'b1;
      bus.data_out  <= res_all;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_dp_gen.sv
// Directed bench for pool_dp_gen: 4x4/K2/S2 single-lane and 6x6/K2/S1 dual-lane instances.
module tb_pool_dp_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, mode_a, done_a;
  logic start_b, mode_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  pool_dp_gen_if #(.DATA_WIDTH(16), .NUM_CH(1)) ifa ();
  pool_dp_gen_if #(.DATA_WIDTH(16), .NUM_CH(2)) ifb ();

  pool_dp_gen #(
    .DATA_WIDTH(16), .NUM_CH(1), .IFM_SIZE(4), .KERNAL_SIZE(2), .STRIDE(2)
  ) u_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode_a), .bus(ifa.slave), .done(done_a)
  );

  pool_dp_gen #(
    .DATA_WIDTH(16), .NUM_CH(2), .IFM_SIZE(6), .KERNAL_SIZE(2), .STRIDE(1)
  ) u_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode_b), .bus(ifb.slave), .done(done_b)
  );

  logic [15:0] outs_a[$];
  logic [31:0] outs_b[$];
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  always @(negedge clk) begin
    if (ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) outs_a.push_back(ifa.data_out);
    if (ifb.out_valid === 1'b1 && ifb.out_ready === 1'b1) outs_b.push_back(ifb.data_out);
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_frame_a(input logic m);
    @(posedge clk); #1;
    start_a = 1'b1; mode_a = m;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic send_a(input logic [15:0] v);
    int g;
    ifa.in_valid = 1'b1;
    ifa.data_in  = v;
    g = 0;
    @(negedge clk);
    while (ifa.in_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (g >= 200) begin
      n_fail++;
      $display("FAIL send_a_timeout: in_ready=%b required 1", ifa.in_ready);
    end
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
  endtask

  task automatic wait_done_a();
    int g;
    g = 0;
    while (done_cnt_a == 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt_a != 1) begin
      n_fail++;
      $display("FAIL done_a_pulses: got %0d required 1", done_cnt_a);
    end
  endtask

  task automatic check_outs_a(input string name, input int e0, input int e1, input int e2, input int e3);
    int exp_v[4];
    logic [15:0] ev;
    exp_v = '{e0, e1, e2, e3};
    n_checks++;
    if (outs_a.size() != 4) begin
      n_fail++;
      $display("FAIL %s_count: got %0d beats required 4", name, outs_a.size());
    end
    for (int i = 0; i < 4; i++) begin
      ev = 16'(exp_v[i]);
      n_checks++;
      if (i >= outs_a.size()) begin
        n_fail++;
        $display("FAIL %s_beat%0d: missing, required %0d", name, i, exp_v[i]);
      end else if (outs_a[i] !== ev) begin
        n_fail++;
        $display("FAIL %s_beat%0d: got %0d required %0d", name, i, $signed(outs_a[i]), exp_v[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_a: got %b required 0", ifa.in_ready); end
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid_a: got %b required 0", ifa.out_valid); end
    n_checks++; if (ifa.data_out !== 16'h0) begin n_fail++; $display("FAIL rst_data_out_a: got %h required 0", ifa.data_out); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rst_done_a: got %b required 0", done_a); end
    n_checks++; if (ifb.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_b: got %b required 0", ifb.in_ready); end
    n_checks++; if (ifb.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid_b: got %b required 0", ifb.out_valid); end
    n_checks++; if (ifb.data_out !== 32'h0) begin n_fail++; $display("FAIL rst_data_out_b: got %h required 0", ifb.data_out); end
    n_checks++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL rst_done_b: got %b required 0", done_b); end
  endtask

  // Max frame; a mid-frame start with mode=avg must be ignored.
  task automatic test_max();
    outs_a.delete(); done_cnt_a = 0;
    ifa.out_ready = 1'b1;
    start_frame_a(1'b1);
    for (int i = 0; i < 8; i++) send_a(16'(i));
    start_a = 1'b1; mode_a = 1'b0;
    send_a(16'd8);
    start_a = 1'b0;
    for (int i = 9; i < 16; i++) send_a(16'(i));
    wait_done_a();
    check_outs_a("max", 5, 7, 13, 15);
  endtask

  task automatic test_avg();
    outs_a.delete(); done_cnt_a = 0;
    start_frame_a(1'b0);
    for (int i = 0; i < 16; i++) send_a(16'(i));
    wait_done_a();
    check_outs_a("avg", 2, 4, 10, 12);
  endtask

  task automatic test_avg_negative();
    logic [15:0] px [16];
    int exp0;
    for (int i = 0; i < 16; i++) px[i] = 16'h0;
    px[0] = 16'hFFFF; px[1] = 16'hFFFE; px[4] = 16'hFFFD; px[5] = 16'hFFFC;
`ifdef POOL_RELU_EN
    exp0 = 0;
`else
    exp0 = -3;
`endif
    outs_a.delete(); done_cnt_a = 0;
    start_frame_a(1'b0);
    for (int i = 0; i < 16; i++) send_a(px[i]);
    wait_done_a();
    check_outs_a("avg_neg", exp0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    int g;
    outs_a.delete(); done_cnt_a = 0;
    ifa.out_ready = 1'b0;
    start_frame_a(1'b1);
    fork
      begin
        for (int i = 0; i < 16; i++) send_a(16'(i));
      end
      begin
        g = 0;
        while (ifa.out_valid !== 1'b1 && g < 100) begin
          @(negedge clk);
          g++;
        end
        held = ifa.data_out;
        n_checks++;
        if (held !== 16'd5) begin
          n_fail++;
          $display("FAIL bp_first_beat: got %0d required 5", held);
        end
        repeat (5) begin
          @(negedge clk);
          n_checks++;
          if (ifa.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready: got %b required 0", ifa.in_ready);
          end
          n_checks++;
          if (ifa.out_valid !== 1'b1 || ifa.data_out !== held) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b data=%0d required valid=1 data=%0d", ifa.out_valid, ifa.data_out, held);
          end
        end
        @(posedge clk); #1;
        ifa.out_ready = 1'b1;
      end
    join
    wait_done_a();
    check_outs_a("bp", 5, 7, 13, 15);
  endtask

  task automatic test_reset_mid_frame();
    outs_a.delete(); done_cnt_a = 0;
    ifa.out_ready = 1'b1;
    start_frame_a(1'b1);
    for (int i = 0; i < 7; i++) send_a(16'(i + 40));
    @(posedge clk); #1;
    reset = 1'b1;
    ifa.in_valid = 1'b1;
    ifa.data_in  = 16'd99;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid: got %b required 0", ifa.out_valid); end
    n_checks++;
    if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b required 0", ifa.in_ready); end
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    outs_a.delete(); done_cnt_a = 0;
    start_frame_a(1'b1);
    for (int i = 0; i < 16; i++) send_a(16'(i));
    wait_done_a();
    check_outs_a("post_rst", 5, 7, 13, 15);
  endtask

  // Stride 1: every beat in rows/cols >= 1 completes a window, back to back.
  task automatic test_two_lane();
    int p [6][6];
    int e0, g, k;
    logic [15:0] l0, l1;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        p[r][c] = ((r * 7 + c * 3) % 11) - 5;
    outs_b.delete(); done_cnt_b = 0;
    ifb.out_ready = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b1; mode_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        ifb.in_valid = 1'b1;
        ifb.data_in  = {16'(p[r][c] + 100), 16'(p[r][c])};
        g = 0;
        @(negedge clk);
        while (ifb.in_ready !== 1'b1 && g < 200) begin
          @(negedge clk);
          g++;
        end
        n_checks++;
        if (g >= 200) begin n_fail++; $display("FAIL send_b_timeout: in_ready=%b required 1", ifb.in_ready); end
        @(posedge clk); #1;
        ifb.in_valid = 1'b0;
      end
    end
    g = 0;
    while (done_cnt_b == 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt_b != 1) begin n_fail++; $display("FAIL done_b_pulses: got %0d required 1", done_cnt_b); end
    n_checks++;
    if (outs_b.size() != 25) begin n_fail++; $display("FAIL b_count: got %0d beats required 25", outs_b.size()); end
    k = 0;
    for (int r = 1; r < 6; r++) begin
      for (int c = 1; c < 6; c++) begin
        e0 = p[r-1][c-1];
        if (p[r-1][c] > e0) e0 = p[r-1][c];
        if (p[r][c-1] > e0) e0 = p[r][c-1];
        if (p[r][c]   > e0) e0 = p[r][c];
        if (k < outs_b.size()) begin
          l0 = outs_b[k][15:0];
          l1 = outs_b[k][31:16];
        end else begin
          l0 = 16'hxxxx;
          l1 = 16'hxxxx;
        end
        n_checks++;
        if (l0 !== 16'(e0)) begin n_fail++; $display("FAIL b_lane0_beat%0d: got %0d required %0d", k, $signed(l0), e0); end
        n_checks++;
        if (l1 !== 16'(e0 + 100)) begin n_fail++; $display("FAIL b_lane1_beat%0d: got %0d required %0d", k, $signed(l1), e0 + 100); end
        k++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; mode_a = 1'b0;
    start_b = 1'b0; mode_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.data_in = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.data_in = '0; ifb.out_ready = 1'b1;
    test_reset();
    test_max();
    test_avg();
    test_avg_negative();
    test_backpressure();
    test_reset_mid_frame();
    test_two_lane();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
